seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for the 8-digit, two-group seven-segment display on the SoC top level (`seg0`, `seg1`, `seg_an`). It accepts a 32-bit hex value plus per-digit decimal-point and blank masks from the MMIO register path. It scans four phases, driving one digit of each 4-digit group per phase, with an optional anti-ghosting blank gap between phases. New values are double-buffered and take effect only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- `SCAN_DIV`, default 100000: cycles each phase is lit; must be ≥1.
- `BLANK_CYCLES`, default 1000: dark cycles after each lit phase; 0 removes the gap state.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  scan enable; 0 forces the display dark.
- `wr_en`  in  1  single-cycle write strobe.
- `wr_value`  in  32  hex digits; digit i = `wr_value[4i+3:4i]`, digit 7 leftmost.
- `wr_dp`  in  8  decimal point per digit.
- `wr_blank`  in  8  force digit i dark (dp included).
- `seg0`  out  8  segments for digits 3..0, {dp,g,f,e,d,c,b,a}, active-high.
- `seg1`  out  8  segments for digits 7..4, same encoding.
- `seg_an`  out  8  digit enables, bit i = digit i, active-high.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.

## Operation
- Registers:
  - pending {value, dp, blank}: loaded on `wr_en`.
  - active set: loaded at frame boundaries.
  - state: IDLE, SHOW, GAP.
  - 2-bit phase.
  - cycle counter: `$clog2(max(SCAN_DIV,BLANK_CYCLES)+1)` bits.
- "Load" means active ← (`wr_en` ? `wr_*` inputs : pending) on that edge. A same-cycle write bypasses the pending register.
- IDLE, when `enable`=1: load, phase←0, counter←0, go to SHOW.
- SHOW, after SCAN_DIV cycles:
  - BLANK_CYCLES>0: go to GAP.
  - BLANK_CYCLES=0: advance directly.
- GAP, after BLANK_CYCLES cycles: advance.
- Advance:
  - Phase 0–2: phase+1, go to SHOW.
  - Phase 3: phase←0, load, pulse `frame_done`, go to SHOW.
- `enable`=0 in any state: next edge goes to IDLE and all outputs go to 0. Pending writes are retained.
- SHOW outputs in phase p:
  - `seg_an` = (1<<p)|(1<<(p+4)).
  - `seg0` = enc(digit p).
  - `seg1` = enc(digit p+4).
- enc rules:
  - Hex glyph with bit7 = dp.
  - Forced to 8'h00 when the blank bit is set.
  - Glyph values, 0–F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- GAP and IDLE: `seg_an`, `seg0`, `seg1` all 0.
- All outputs are registered. Reset value of every output and register is 0, with state = IDLE.

## Timing
- `enable` sampled high at edge N: first lit outputs are visible after edge N+1.
- Each phase is lit for exactly SCAN_DIV cycles, then dark for exactly BLANK_CYCLES cycles.
- Frame period is 4·(SCAN_DIV+BLANK_CYCLES) cycles.
- `frame_done` is high for the one cycle after the edge that loads the new frame.
  - Not pulsed on the IDLE→SHOW load.
- Write-to-display latency: the write appears in the next frame.
  - If `wr_en` coincides with the boundary edge, it appears in the frame starting at that edge.
- Multiple writes within one frame: the last write wins.
- `rst` asserted mid-frame: outputs drop to 0 asynchronously. Scanning resumes from IDLE once `rst` is released and `enable` is high.

## Configuration
- Macro `SEG_LZ_BLANK_EN` enables leading-zero suppression.
- Defined:
  - Digit i (7..1) is dark when its nibble is zero and all higher nibbles are zero.
  - The digit's dp bit is still shown.
  - Digit 0 is never suppressed.
  - Decided from the active value only.
- Undefined: every digit shows its glyph. No extra logic is present.

## Test plan
1. `SCAN_DIV`=4, `BLANK_CYCLES`=2, write 0x76543210, `wr_dp`=0, `enable`=1 → `seg_an` sequence is 11,00,22,00,44,00,88,00 (hex, each lit 4 cycles, dark 2); phase 0 shows `seg0`=3F, `seg1`=66; `frame_done` pulses every 24 cycles.
2. Write 0x00000000 mid-frame, then 0x0000ABCD at the boundary edge → the next frame shows ABCD (`seg0` phase 0 = 5E); the zero value is never displayed.
3. `wr_blank`=0x01, `wr_dp`=0x10 → phase 0 gives `seg0`=00, `seg1`=enc|0x80.
4. `BLANK_CYCLES`=0 → `seg_an` steps 11→22→44→88 every 4 cycles with no dark cycles.
5. `enable` dropped in phase 2 → all outputs 0 on the next edge; re-enable restarts at phase 0 with outputs after one cycle. Async `rst` mid-SHOW → outputs 0 immediately.
6. With `SEG_LZ_BLANK_EN`, value 0x00000105 → digits 7..3 dark, digits 2..0 show 1,0,5; with value 0 only digit 0 shows 3F. Without the macro, all digits are lit.

Source files
------------

// File: rtl/seg_scan_if.sv
// Bus bundle between the MMIO register path and seg_scan_ctrl: write strobe/data in,
// scanned segment/anode drive and frame pulse out.
interface seg_scan_if;
    logic        enable;
    logic        wr_en;
    logic [31:0] wr_value;
    logic [7:0]  wr_dp;
    logic [7:0]  wr_blank;
    logic [7:0]  seg0;
    logic [7:0]  seg1;
    logic [7:0]  seg_an;
    logic        frame_done;

    modport master (
        output enable, wr_en, wr_value, wr_dp, wr_blank,
        input  seg0, seg1, seg_an, frame_done
    );

    modport slave (
        input  enable, wr_en, wr_value, wr_dp, wr_blank,
        output seg0, seg1, seg_an, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-phase scan controller for two 4-digit seven-segment groups with frame-boundary
// double buffering. Optional macro SEG_LZ_BLANK_EN adds leading-zero suppression.
module seg_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  bus
);

    localparam int unsigned MAX_CYC = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 32'd1);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SCAN_DIV - 32'd1);
    localparam logic [CNT_W-1:0] GAP_LAST  = (BLANK_CYCLES == 32'd0) ? '0 : CNT_W'(BLANK_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_value_q, pend_value_d;
    logic [7:0]       pend_dp_q, pend_dp_d;
    logic [7:0]       pend_blank_q, pend_blank_d;
    logic [31:0]      act_value_q, act_value_d;
    logic [7:0]       act_dp_q, act_dp_d;
    logic [7:0]       act_blank_q, act_blank_d;
    logic [7:0]       seg0_q, seg0_d;
    logic [7:0]       seg1_q, seg1_d;
    logic [7:0]       seg_an_q, seg_an_d;
    logic             frame_done_q, frame_done_d;

    logic             load_s;
    logic             advance_s;
    logic [2:0]       lo_idx_s;
    logic [2:0]       hi_idx_s;
    logic [7:0]       lz_s;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            4'hF: g = 7'h71;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    // Blank wins over everything; a suppressed leading zero still keeps its dp.
    function automatic logic [7:0] enc_digit(input logic [3:0] nib, input logic dp,
                                             input logic blank, input logic lz);
        logic [7:0] s;
        if (blank) begin
            s = 8'h00;
        end else if (lz) begin
            s = {dp, 7'h00};
        end else begin
            s = {dp, hex_glyph(nib)};
        end
        return s;
    endfunction

`ifdef SEG_LZ_BLANK_EN
    logic zero_above_s;

    // Leading-zero mask from the active value; digit 0 is never suppressed.
    always_comb begin
        lz_s         = 8'h00;
        zero_above_s = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            zero_above_s = zero_above_s & (act_value_q[4*i +: 4] == 4'h0);
            lz_s[i]      = zero_above_s;
        end
    end
`else
    assign lz_s = 8'h00;
`endif

    assign lo_idx_s = {1'b0, phase_q};
    assign hi_idx_s = {1'b1, phase_q};

    // Scan sequencing: phase timing, gap insertion and frame-boundary loads.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        load_s       = 1'b0;
        advance_s    = 1'b0;
        frame_done_d = 1'b0;
        if (!bus.enable) begin
            state_d = ST_IDLE;
            phase_d = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    load_s  = 1'b1;
                    phase_d = 2'd0;
                    cnt_d   = '0;
                    state_d = ST_SHOW;
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_d = '0;
                        if (BLANK_CYCLES > 32'd0) begin
                            state_d = ST_GAP;
                        end else begin
                            advance_s = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d     = '0;
                        advance_s = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    phase_d = 2'd0;
                    cnt_d   = '0;
                end
            endcase

            if (advance_s) begin
                state_d = ST_SHOW;
                if (phase_q == 2'd3) begin
                    phase_d      = 2'd0;
                    load_s       = 1'b1;
                    frame_done_d = 1'b1;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end else begin
                frame_done_d = 1'b0;
            end
        end
    end

    // Pending buffer tracks the latest write; the active set takes a same-cycle write directly.
    always_comb begin
        pend_value_d = pend_value_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        act_value_d  = act_value_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        if (bus.wr_en) begin
            pend_value_d = bus.wr_value;
            pend_dp_d    = bus.wr_dp;
            pend_blank_d = bus.wr_blank;
        end else begin
            pend_value_d = pend_value_q;
        end
        if (load_s) begin
            act_value_d = bus.wr_en ? bus.wr_value : pend_value_q;
            act_dp_d    = bus.wr_en ? bus.wr_dp    : pend_dp_q;
            act_blank_d = bus.wr_en ? bus.wr_blank : pend_blank_q;
        end else begin
            act_value_d = act_value_q;
        end
    end

    // Segment and anode drive for the phase currently held in state_q/phase_q.
    always_comb begin
        seg0_d   = 8'h00;
        seg1_d   = 8'h00;
        seg_an_d = 8'h00;
        if (bus.enable && (state_q == ST_SHOW)) begin
            seg_an_d[lo_idx_s] = 1'b1;
            seg_an_d[hi_idx_s] = 1'b1;
            seg0_d = enc_digit(act_value_q[{lo_idx_s, 2'b00} +: 4], act_dp_q[lo_idx_s],
                               act_blank_q[lo_idx_s], lz_s[lo_idx_s]);
            seg1_d = enc_digit(act_value_q[{hi_idx_s, 2'b00} +: 4], act_dp_q[hi_idx_s],
                               act_blank_q[hi_idx_s], lz_s[hi_idx_s]);
        end else begin
            seg_an_d = 8'h00;
        end
    end

    // State, buffers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= 2'd0;
            cnt_q        <= '0;
            pend_value_q <= 32'h0000_0000;
            pend_dp_q    <= 8'h00;
            pend_blank_q <= 8'h00;
            act_value_q  <= 32'h0000_0000;
            act_dp_q     <= 8'h00;
            act_blank_q  <= 8'h00;
            seg0_q       <= 8'h00;
            seg1_q       <= 8'h00;
            seg_an_q     <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            pend_value_q <= pend_value_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            act_value_q  <= act_value_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            seg0_q       <= seg0_d;
            seg1_q       <= seg1_d;
            seg_an_q     <= seg_an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg0       = seg0_q;
    assign bus.seg1       = seg1_q;
    assign bus.seg_an     = seg_an_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (with and without blank gap) driven identically,
// checked every cycle against a frame-timeline reference model.
module tb_seg_scan_ctrl;

    localparam int S  = 4;
    localparam int BA = 2;
    localparam int BB = 0;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        wr_en;
    logic [31:0] wr_value;
    logic [7:0]  wr_dp;
    logic [7:0]  wr_blank;

    int total;
    int bad;

    seg_scan_if ifa ();
    seg_scan_if ifb ();

    assign ifa.enable   = enable;
    assign ifa.wr_en    = wr_en;
    assign ifa.wr_value = wr_value;
    assign ifa.wr_dp    = wr_dp;
    assign ifa.wr_blank = wr_blank;
    assign ifb.enable   = enable;
    assign ifb.wr_en    = wr_en;
    assign ifb.wr_value = wr_value;
    assign ifb.wr_dp    = wr_dp;
    assign ifb.wr_blank = wr_blank;

    seg_scan_ctrl #(.SCAN_DIV(S), .BLANK_CYCLES(BA)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    seg_scan_ctrl #(.SCAN_DIV(S), .BLANK_CYCLES(BB)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: e_m = edges since the scan started (-1 when idle).
    logic [6:0]  glyph_m [16];
    int          e_m [2];
    logic [31:0] pv_m;
    logic [7:0]  pd_m, pb_m;
    logic [31:0] av_m [2];
    logic [7:0]  ad_m [2];
    logic [7:0]  ab_m [2];
    logic [24:0] exp_m [2];

    function automatic logic [7:0] enc_m(input logic [31:0] v, input logic [7:0] dp,
                                         input logic [7:0] bl, input int i);
        logic [7:0] r;
        logic [3:0] nib;
        nib = 4'(v >> (4 * i));
        r = {dp[i], glyph_m[nib]};
`ifdef SEG_LZ_BLANK_EN
        if (i > 0 && (v >> (4 * i)) == 32'd0) r[6:0] = 7'h00;
`endif
        if (bl[i]) r = 8'h00;
        return r;
    endfunction

    function automatic logic [24:0] obs(input int d);
        if (d == 0) return {ifa.seg_an, ifa.seg0, ifa.seg1, ifa.frame_done};
        return {ifb.seg_an, ifb.seg0, ifb.seg1, ifb.frame_done};
    endfunction

    task automatic model_reset();
        pv_m = 32'd0; pd_m = 8'd0; pb_m = 8'd0;
        for (int d = 0; d < 2; d++) begin
            e_m[d] = -1; av_m[d] = 32'd0; ad_m[d] = 8'd0; ab_m[d] = 8'd0; exp_m[d] = 25'd0;
        end
    endtask

    task automatic model_edge();
        int l, p, u, r, ph;
        for (int d = 0; d < 2; d++) begin
            l = S + ((d == 0) ? BA : BB);
            p = 4 * l;
            exp_m[d] = 25'd0;
            if (rst) begin
                e_m[d] = -1; av_m[d] = 32'd0; ad_m[d] = 8'd0; ab_m[d] = 8'd0;
            end else if (!enable) begin
                e_m[d] = -1;
            end else if (e_m[d] < 0) begin
                e_m[d] = 0;
                av_m[d] = wr_en ? wr_value : pv_m;
                ad_m[d] = wr_en ? wr_dp : pd_m;
                ab_m[d] = wr_en ? wr_blank : pb_m;
            end else begin
                e_m[d] = e_m[d] + 1;
                u = e_m[d] - 1;
                r = u % p;
                ph = r / l;
                if ((r % l) < S)
                    exp_m[d][24:1] = {8'((1 << ph) | (1 << (ph + 4))),
                                      enc_m(av_m[d], ad_m[d], ab_m[d], ph),
                                      enc_m(av_m[d], ad_m[d], ab_m[d], ph + 4)};
                if (e_m[d] % p == 0) begin
                    exp_m[d][0] = 1'b1;
                    av_m[d] = wr_en ? wr_value : pv_m;
                    ad_m[d] = wr_en ? wr_dp : pd_m;
                    ab_m[d] = wr_en ? wr_blank : pb_m;
                end
            end
        end
        if (rst) begin
            pv_m = 32'd0; pd_m = 8'd0; pb_m = 8'd0;
        end else if (wr_en) begin
            pv_m = wr_value; pd_m = wr_dp; pb_m = wr_blank;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; wr_en = 1'b0;
        wr_value = 32'd0; wr_dp = 8'd0; wr_blank = 8'd0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (obs(d) !== 25'd0) begin
                bad++; $display("FAIL reset_state dut%0d got=%h exp=%h", d, obs(d), 25'd0);
            end
        end
        cyc(); cyc();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs(d) !== exp_m[d]) begin
                    bad++; $display("FAIL reset_idle dut%0d t=%0t got=%h exp=%h", d, $time, obs(d), exp_m[d]);
                end
            end
        end
    endtask

    task automatic test_basic_scan();
        int fd_a, fd_b;
        fd_a = 0; fd_b = 0;
        wr_en = 1'b1; wr_value = 32'h7654_3210; wr_dp = 8'h00; wr_blank = 8'h00;
        cyc();
        wr_en = 1'b0;
        enable = 1'b1;
        cyc(); cyc();
        total++;
        if ({ifa.seg_an, ifa.seg0, ifa.seg1} !== 24'h113F66) begin
            bad++; $display("FAIL first_lit got=%h exp=%h", {ifa.seg_an, ifa.seg0, ifa.seg1}, 24'h113F66);
        end
        for (int k = 0; k < 48; k++) begin
            cyc();
            fd_a += int'(ifa.frame_done);
            fd_b += int'(ifb.frame_done);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs(d) !== exp_m[d]) begin
                    bad++; $display("FAIL basic_scan dut%0d t=%0t got=%h exp=%h", d, $time, obs(d), exp_m[d]);
                end
            end
        end
        total++;
        if (fd_a != 2 || fd_b != 3) begin
            bad++; $display("FAIL frame_pulses got=%0d/%0d exp=2/3", fd_a, fd_b);
        end
    endtask

    task automatic test_boundary_write();
        for (int k = 0; k < 30 && (e_m[0] % 24) != 10; k++) cyc();
        wr_en = 1'b1; wr_value = 32'h0000_0000;
        cyc();
        wr_en = 1'b0;
        for (int k = 0; k < 30 && ((e_m[0] + 1) % 24) != 0; k++) begin
            cyc();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs(d) !== exp_m[d]) begin
                    bad++; $display("FAIL bnd_pre dut%0d t=%0t got=%h exp=%h", d, $time, obs(d), exp_m[d]);
                end
            end
        end
        wr_en = 1'b1; wr_value = 32'h0000_ABCD;
        cyc();
        wr_en = 1'b0;
        cyc();
        total++;
        if ({ifa.seg_an, ifa.seg0} !== 16'h115E) begin
            bad++; $display("FAIL bnd_write got=%h exp=%h", {ifa.seg_an, ifa.seg0}, 16'h115E);
        end
        for (int k = 0; k < 24; k++) begin
            cyc();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs(d) !== exp_m[d]) begin
                    bad++; $display("FAIL bnd_post dut%0d t=%0t got=%h exp=%h", d, $time, obs(d), exp_m[d]);
                end
            end
        end
    endtask

    task automatic test_blank_dp();
        enable = 1'b0;
        cyc();
        wr_en = 1'b1; wr_value = 32'h7654_3210; wr_dp = 8'h10; wr_blank = 8'h01;
        cyc();
        wr_en = 1'b0; enable = 1'b1;
        cyc(); cyc();
        total++;
        if ({ifa.seg_an, ifa.seg0, ifa.seg1} !== 24'h1100E6) begin
            bad++; $display("FAIL blank_dp got=%h exp=%h", {ifa.seg_an, ifa.seg0, ifa.seg1}, 24'h1100E6);
        end
        for (int k = 0; k < 26; k++) begin
            cyc();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs(d) !== exp_m[d]) begin
                    bad++; $display("FAIL blank_dp_scan dut%0d t=%0t got=%h exp=%h", d, $time, obs(d), exp_m[d]);
                end
            end
        end
    endtask

    task automatic test_no_gap();
        int dark_b;
        dark_b = 0;
        for (int k = 0; k < 40; k++) begin
            wr_en = (k == 13);
            wr_value = $urandom; wr_dp = 8'($urandom); wr_blank = 8'h00;
            cyc();
            if (ifb.seg_an == 8'h00) dark_b++;
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs(d) !== exp_m[d]) begin
                    bad++; $display("FAIL no_gap dut%0d t=%0t got=%h exp=%h", d, $time, obs(d), exp_m[d]);
                end
            end
        end
        wr_en = 1'b0;
        total++;
        if (dark_b != 0) begin
            bad++; $display("FAIL no_gap_dark got=%0d exp=0", dark_b);
        end
    endtask

    task automatic test_enable_reset();
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 30 && !hit; k++) begin
            cyc();
            hit = (ifa.seg_an == 8'h44);
        end
        total++;
        if (!hit) begin
            bad++; $display("FAIL wait_phase2 got=%h exp=%h", ifa.seg_an, 8'h44);
        end
        enable = 1'b0;
        cyc();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (obs(d) !== 25'd0) begin
                bad++; $display("FAIL en_drop dut%0d got=%h exp=%h", d, obs(d), 25'd0);
            end
        end
        cyc();
        enable = 1'b1;
        cyc(); cyc();
        total++;
        if (ifa.seg_an !== 8'h11) begin
            bad++; $display("FAIL re_enable got=%h exp=%h", ifa.seg_an, 8'h11);
        end
        for (int k = 0; k < 10; k++) begin
            cyc();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs(d) !== exp_m[d]) begin
                    bad++; $display("FAIL en_scan dut%0d t=%0t got=%h exp=%h", d, $time, obs(d), exp_m[d]);
                end
            end
        end
        for (int k = 0; k < 10 && ifa.seg_an == 8'h00; k++) cyc();
        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (obs(d) !== 25'd0) begin
                bad++; $display("FAIL async_rst dut%0d got=%h exp=%h", d, obs(d), 25'd0);
            end
        end
        cyc(); cyc();
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs(d) !== exp_m[d]) begin
                    bad++; $display("FAIL post_rst dut%0d t=%0t got=%h exp=%h", d, $time, obs(d), exp_m[d]);
                end
            end
        end
    endtask

    task automatic test_lz();
        logic [23:0] exp_105, exp_0;
`ifdef SEG_LZ_BLANK_EN
        exp_105 = 24'h116D00; exp_0 = 24'h113F00;
`else
        exp_105 = 24'h116D3F; exp_0 = 24'h113F3F;
`endif
        for (int v = 0; v < 2; v++) begin
            enable = 1'b0;
            cyc();
            wr_en = 1'b1; wr_value = (v == 0) ? 32'h0000_0105 : 32'h0; wr_dp = 8'h00; wr_blank = 8'h00;
            cyc();
            wr_en = 1'b0; enable = 1'b1;
            cyc(); cyc();
            total++;
            if ({ifa.seg_an, ifa.seg0, ifa.seg1} !== ((v == 0) ? exp_105 : exp_0)) begin
                bad++; $display("FAIL lz_ph0 v%0d got=%h exp=%h", v, {ifa.seg_an, ifa.seg0, ifa.seg1},
                                (v == 0) ? exp_105 : exp_0);
            end
            for (int k = 0; k < 24; k++) begin
                cyc();
                for (int d = 0; d < 2; d++) begin
                    total++;
                    if (obs(d) !== exp_m[d]) begin
                        bad++; $display("FAIL lz_scan dut%0d t=%0t got=%h exp=%h", d, $time, obs(d), exp_m[d]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        enable = 1'b1;
        for (int k = 0; k < 1200; k++) begin
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            wr_en = ($urandom_range(0, 7) == 0);
            wr_value = $urandom >> $urandom_range(0, 31);
            wr_dp = 8'($urandom);
            wr_blank = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            cyc();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs(d) !== exp_m[d]) begin
                    bad++; $display("FAIL random dut%0d t=%0t got=%h exp=%h", d, $time, obs(d), exp_m[d]);
                end
            end
        end
        wr_en = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        glyph_m = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        model_reset();
        test_reset();
        test_basic_scan();
        test_boundary_write();
        test_blank_dp();
        test_no_gap();
        test_enable_reset();
        test_lz();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
